// File: rtl/score_converter_pkg.sv
// score_converter_pkg: segment patterns, FSM states and BCD sizing shared by the score display path.
package score_converter_pkg;
   localparam int BCD_DIGITS = 10;
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_e;
endpackage

// File: rtl/score_converter_seg7_decoder.sv
// seg7_decoder: one BCD nibble to active-low segments (bit0=a .. bit6=g); non-decimal codes blank.
module seg7_decoder
   import score_converter_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   assign seg = bcd == 4'd0 ? SEG_0 :
                bcd == 4'd1 ? SEG_1 :
                bcd == 4'd2 ? SEG_2 :
                bcd == 4'd3 ? SEG_3 :
                bcd == 4'd4 ? SEG_4 :
                bcd == 4'd5 ? SEG_5 :
                bcd == 4'd6 ? SEG_6 :
                bcd == 4'd7 ? SEG_7 :
                bcd == 4'd8 ? SEG_8 :
                bcd == 4'd9 ? SEG_9 : SEG_OFF;
endmodule

// File: rtl/score_converter.sv
// score_converter: sequential double-dabble of the binary score, showing the low four decimal
// digits on registered active-low 7-segment outputs that only update with complete results.
module score_converter
   import score_converter_pkg::*;
#(
   parameter int SCORE_W = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   output logic [6:0]         score_digit_a,
   output logic [6:0]         score_digit_b,
   output logic [6:0]         score_digit_c,
   output logic [6:0]         score_digit_d
);
   localparam int CNT_W = $clog2(SCORE_W);
   localparam int BCD_W = 4 * BCD_DIGITS;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SCORE_W-1:0] shift_q, shift_d, last_q, last_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d, adj;
   logic [27:0]        seg_q, seg_d;
   logic [6:0]         dec_a, dec_b, dec_c, dec_d;

   seg7_decoder u_dec_a (.bcd(bcd_q[15:12]), .seg(dec_a));
   seg7_decoder u_dec_b (.bcd(bcd_q[11:8]),  .seg(dec_b));
   seg7_decoder u_dec_c (.bcd(bcd_q[7:4]),   .seg(dec_c));
   seg7_decoder u_dec_d (.bcd(bcd_q[3:0]),   .seg(dec_d));

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      seg_d   = seg_q;
      case (state_q)
         IDLE: if (score != last_q) begin
            shift_d = score;
            last_d  = score;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            {bcd_d, shift_d} = {adj, shift_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(SCORE_W - 1)) state_d = LOAD;
         end
         LOAD: begin
            seg_d   = {dec_a, dec_b, dec_c, dec_d};
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         last_q  <= '0;
         bcd_q   <= '0;
         seg_q   <= {4{SEG_0}};
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         bcd_q   <= bcd_d;
         seg_q   <= seg_d;
      end

   assign {score_digit_a, score_digit_b, score_digit_c, score_digit_d} = seg_q;
endmodule

// File: tb/tb_score_converter.sv
// tb_score_converter: table-driven score vectors with a scoreboard of expected display patterns
// consumed whenever the outputs change, plus hand-written overlap and mid-conversion reset cases.
module tb_score_converter;
   typedef struct {
      logic [31:0] score;
      logic [15:0] disp;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] score = '0;
   logic [6:0]  a, b, c, d;
   logic [27:0] out;
   logic [27:0] prev;
   logic [27:0] q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   vec_t        vecs[7];

   always #5 clock = ~clock;

   score_converter #(.SCORE_W(32)) dut (
      .clock(clock), .reset(reset), .score(score),
      .score_digit_a(a), .score_digit_b(b), .score_digit_c(c), .score_digit_d(d)
   );

   assign out = {a, b, c, d};

   function automatic logic [6:0] seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [27:0] pat(input logic [15:0] v);
      return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
   endfunction

   task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_drain(input int lim, input string name);
      int i = 0;
      while (q.size() != 0 && i < lim) begin
         @(negedge clock);
         #1;
         i++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d results still pending after %0d clocks", name, q.size(), lim);
         q.delete();
      end
   endtask

   // Any output change must be exactly the next expected display; partial values fail here.
   always @(negedge clock) begin
      if (!reset) prev = out;
      else if (out !== prev) begin
         if (q.size() == 0) check("unexpected_change", out, prev);
         else check("scoreboard", out, q.pop_front());
         prev = out;
      end
   end

   initial begin
      vecs[0] = '{32'd1234,       16'h1234};
      vecs[1] = '{32'd12345,      16'h2345};
      vecs[2] = '{32'hFFFFFFFF,   16'h7295};
      vecs[3] = '{32'd9999,       16'h9999};
      vecs[4] = '{32'd10000,      16'h0000};
      vecs[5] = '{32'd42,         16'h0042};
      vecs[6] = '{32'd1000000007, 16'h0007};
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      check("reset_state", out, {4{7'b1000000}});
      repeat (40) @(posedge clock);
      #1 check("idle_hold", out, {4{7'b1000000}});
      for (int i = 0; i < 7; i++) begin
         @(posedge clock);
         #1 score = vecs[i].score;
         q.push_back(pat(vecs[i].disp));
         wait_drain(35, "vec_latency");
         repeat (5) @(negedge clock);
         check("vec_stable", out, pat(vecs[i].disp));
         if (i == 0) check("literal_1234", out, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
         if (i == 2) check("literal_7295", out, {7'b1111000, 7'b0100100, 7'b0010000, 7'b0010010});
      end
      @(posedge clock);
      #1 score = 32'd5555;
      q.push_back(pat(16'h5555));
      q.push_back(pat(16'h6789));
      repeat (5) @(posedge clock);
      #1 score = 32'd6789;
      wait_drain(64, "overlap_latency");
      repeat (5) @(negedge clock);
      check("overlap_final", out, pat(16'h6789));
      @(posedge clock);
      #1 score = 32'd8888;
      q.push_back(pat(16'h8888));
      repeat (10) @(posedge clock);
      #1 reset = 1'b0;
      #1 check("reset_abort", out, {4{7'b1000000}});
      repeat (3) @(negedge clock);
      check("reset_hold", out, {4{7'b1000000}});
      @(posedge clock);
      #1 reset = 1'b1;
      wait_drain(35, "post_reset_latency");
      repeat (5) @(negedge clock);
      check("post_reset", out, pat(16'h8888));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
